// File: rtl/rx_pkg.sv
// Shared definitions for the serial receive front end: FSM state codes,
// default frame geometry and the frame-length helper.
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  localparam int DEF_OVS       = 16;
  localparam int DEF_DATA_BITS = 8;
  localparam int DEF_PARITY_EN = 1;

  function automatic int frame_bits(input int data_bits, input int parity_en);
    return data_bits + parity_en;
  endfunction

endpackage

// File: rtl/rx_sync_vote.sv
// Two-flop synchroniser for the raw rx line plus a sample history taken on
// oversample ticks; produces the 3-sample majority and unanimity flags.
module rx_sync_vote (
  input  logic clk,
  input  logic rst,
  input  logic tick_en,
  input  logic rx,
  output logic rx_s,
  output logic vote,
  output logic unan
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] hist_q, hist_d;
  logic       s0, s1, s2;

  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    hist_d  = hist_q;
    if (tick_en) begin
      hist_d = {hist_q[0], sync2_q};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 2'b11;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  // On a vote tick the window is the two previous ticks plus the current sample.
  assign s0   = hist_q[1];
  assign s1   = hist_q[0];
  assign s2   = sync2_q;
  assign rx_s = sync2_q;
  assign vote = (s0 & s1) | (s0 & s2) | (s1 & s2);
  assign unan = (s0 & s1 & s2) | ~(s0 | s1 | s2);

endmodule

// File: rtl/rx_bit_sampler.sv
// Receive bit sampler: start-bit qualification, mid-bit majority sampling of
// data/parity bits, stop-bit check and line-break hold-off.
module rx_bit_sampler
  import rx_pkg::*;
#(
  parameter int OVS       = DEF_OVS,
  parameter int DATA_BITS = DEF_DATA_BITS,
  parameter int PARITY_EN = DEF_PARITY_EN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic       rx,
  output logic       strt_beg,
  output logic       rx_bit,
  output logic       bit_vld,
  output logic       frame_done,
  output logic       rx_err,
  output logic       noise_err,
  output logic       busy,
  output logic [2:0] dbg_state
);

  localparam int TW    = $clog2(OVS);
  localparam int NBITS = frame_bits(DATA_BITS, PARITY_EN);
  localparam logic [TW-1:0] T_VOTE  = TW'(OVS / 2 + 1);
  localparam logic [TW-1:0] T_ALIGN = TW'(OVS / 2 + 2);
  localparam logic [TW-1:0] T_LAST  = TW'(OVS - 1);
  localparam logic [3:0]    B_LAST  = 4'(NBITS - 1);

  rx_state_e     state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d, tcnt_inc;
  logic [3:0]    bcnt_q, bcnt_d;
  logic          strt_beg_q, strt_beg_d;
  logic          rx_bit_q, rx_bit_d;
  logic          bit_vld_q, bit_vld_d;
  logic          frame_done_q, frame_done_d;
  logic          rx_err_q, rx_err_d;
  logic          noise_err_q, noise_err_d;
  logic          rx_s, vote, unan, at_vote;

  rx_sync_vote u_sync_vote (
    .clk    (clk),
    .rst    (rst),
    .tick_en(tick_en),
    .rx     (rx),
    .rx_s   (rx_s),
    .vote   (vote),
    .unan   (unan)
  );

  assign tcnt_inc = (tcnt_q == T_LAST) ? '0 : tcnt_q + TW'(1);
  assign at_vote  = (tcnt_q == T_VOTE);

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bcnt_d       = bcnt_q;
    strt_beg_d   = strt_beg_q;
    rx_bit_d     = rx_bit_q;
    bit_vld_d    = 1'b0;
    frame_done_d = 1'b0;
    rx_err_d     = rx_err_q;
    noise_err_d  = noise_err_q;
    if (tick_en) begin
      unique case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tcnt_d  = '0;
          end
        end
        START: begin
          if (!at_vote) begin
            tcnt_d = tcnt_inc;
          end else if (vote) begin
            state_d = IDLE;
          end else begin
            // Jump the counter so the next vote falls OVS ticks later, mid bit 0.
            state_d     = DATA;
            strt_beg_d  = 1'b1;
            rx_err_d    = 1'b0;
            noise_err_d = ~unan;
            tcnt_d      = T_ALIGN;
            bcnt_d      = '0;
          end
        end
        DATA: begin
          tcnt_d = tcnt_inc;
          if (at_vote) begin
            rx_bit_d  = vote;
            bit_vld_d = 1'b1;
            if (!unan) noise_err_d = 1'b1;
            if (bcnt_q == B_LAST) state_d = STOP;
            else                  bcnt_d  = bcnt_q + 4'd1;
          end
        end
        STOP: begin
          tcnt_d = tcnt_inc;
          if (at_vote) begin
            frame_done_d = 1'b1;
            strt_beg_d   = 1'b0;
            rx_err_d     = ~vote;
            if (!unan) noise_err_d = 1'b1;
            state_d = vote ? IDLE : BREAK;
          end
        end
        BREAK: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      tcnt_q       <= '0;
      bcnt_q       <= '0;
      strt_beg_q   <= 1'b0;
      rx_bit_q     <= 1'b0;
      bit_vld_q    <= 1'b0;
      frame_done_q <= 1'b0;
      rx_err_q     <= 1'b0;
      noise_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      bcnt_q       <= bcnt_d;
      strt_beg_q   <= strt_beg_d;
      rx_bit_q     <= rx_bit_d;
      bit_vld_q    <= bit_vld_d;
      frame_done_q <= frame_done_d;
      rx_err_q     <= rx_err_d;
      noise_err_q  <= noise_err_d;
    end
  end

  assign strt_beg   = strt_beg_q;
  assign rx_bit     = rx_bit_q;
  assign bit_vld    = bit_vld_q;
  assign frame_done = frame_done_q;
  assign rx_err     = rx_err_q;
  assign noise_err  = noise_err_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rx_bit_sampler.sv
// Directed bench for rx_bit_sampler: frames are driven one oversample tick at a
// time, received bits are scored against an expected queue.
module tb_rx_bit_sampler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_en = 1'b0;
  logic       rx = 1'b1;
  logic       strt_beg, rx_bit, bit_vld, frame_done, rx_err, noise_err, busy;
  logic [2:0] dbg_state;

  rx_bit_sampler #(.OVS(16), .DATA_BITS(8), .PARITY_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_en   (tick_en),
    .rx        (rx),
    .strt_beg  (strt_beg),
    .rx_bit    (rx_bit),
    .bit_vld   (bit_vld),
    .frame_done(frame_done),
    .rx_err    (rx_err),
    .noise_err (noise_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset / tick generation
  always #5 clk = ~clk;

  int tick_div = 0;
  always @(negedge clk) begin
    tick_div = (tick_div == 3) ? 0 : tick_div + 1;
    tick_en  = (tick_div == 0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got running, need finished");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [0:0] exp_q[$];
  int         vld_cnt = 0;
  int         frame_cnt = 0;
  int         err_cnt = 0;
  bit         strt_seen = 1'b0;
  int         abort_at = -1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bit_vld) begin
        vld_cnt++;
        if (exp_q.size() == 0) chk("unexpected_bit_vld", 32'd1, 32'd0);
        else chk("rx_bit", {31'd0, rx_bit}, {31'd0, exp_q.pop_front()});
      end
      if (frame_done) begin
        frame_cnt++;
        if (rx_err) err_cnt++;
      end
      if (strt_beg) strt_seen = 1'b1;
    end
  end

  // driver tasks
  task automatic drive_tick(input logic v);
    @(negedge clk);
    rx = v;
    do @(posedge clk); while (!tick_en);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) drive_tick(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_outputs", {25'd0, strt_beg, rx_bit, bit_vld, frame_done, rx_err, noise_err, busy}, 32'd0);
    chk("reset_state", {29'd0, dbg_state}, 32'd0);
    exp_q.delete();
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // start, 8 data LSB first, even parity, stop; optional one-tick inversion mid data bit
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int glitch_bit);
    logic [10:0] fr;
    logic        lvl;
    fr = {stop_v, ^d, d, 1'b0};
    for (int k = 0; k < 9; k++) exp_q.push_back(fr[k+1]);
    for (int b = 0; b < 11; b++) begin
      for (int i = 0; i < 16; i++) begin
        if (abort_at >= 0 && vld_cnt >= abort_at) begin
          do_reset();
          return;
        end
        lvl = fr[b];
        if (glitch_bit >= 0 && b == glitch_bit + 1 && i == 9) lvl = ~lvl;
        drive_tick(lvl);
      end
    end
  endtask

  int v0, f0, e0;

  initial begin
    #1;
    chk("reset_outputs", {25'd0, strt_beg, rx_bit, bit_vld, frame_done, rx_err, noise_err, busy}, 32'd0);
    chk("reset_state", {29'd0, dbg_state}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle_ticks(8);

    // clean 0xA5
    v0 = vld_cnt; f0 = frame_cnt; e0 = err_cnt; strt_seen = 1'b0;
    send_frame(8'hA5, 1'b1, -1);
    chk("a5_vld_count", vld_cnt - v0, 32'd9);
    chk("a5_frames", frame_cnt - f0, 32'd1);
    chk("a5_rx_err", err_cnt - e0, 32'd0);
    chk("a5_strt_seen", {31'd0, strt_seen}, 32'd1);
    chk("a5_noise", {31'd0, noise_err}, 32'd0);
    chk("a5_idle", {30'd0, busy, strt_beg}, 32'd0);
    idle_ticks(4);

    // false start: 4 low ticks
    v0 = vld_cnt; strt_seen = 1'b0;
    for (int i = 0; i < 4; i++) drive_tick(1'b0);
    chk("fs_busy_during", {31'd0, busy}, 32'd1);
    idle_ticks(16);
    chk("fs_busy_after", {31'd0, busy}, 32'd0);
    chk("fs_strt_beg", {31'd0, strt_seen}, 32'd0);
    chk("fs_no_vld", vld_cnt - v0, 32'd0);

    // 0x3C with bad stop, then 20 bit times of break
    v0 = vld_cnt; f0 = frame_cnt; e0 = err_cnt;
    send_frame(8'h3C, 1'b0, -1);
    chk("brk_frames", frame_cnt - f0, 32'd1);
    chk("brk_rx_err", err_cnt - e0, 32'd1);
    for (int i = 0; i < 320; i++) drive_tick(1'b0);
    chk("brk_state", {29'd0, dbg_state}, 32'd4);
    chk("brk_no_extra_vld", vld_cnt - v0, 32'd9);
    chk("brk_no_extra_frame", frame_cnt - f0, 32'd1);
    idle_ticks(4);
    chk("brk_exit_busy", {31'd0, busy}, 32'd0);
    chk("brk_err_held", {31'd0, rx_err}, 32'd1);

    // 0xFF with glitch mid bit 3, then clean frame
    send_frame(8'hFF, 1'b1, 3);
    chk("glitch_noise", {31'd0, noise_err}, 32'd1);
    chk("glitch_err_cleared", {31'd0, rx_err}, 32'd0);
    idle_ticks(2);
    send_frame(8'h00, 1'b1, -1);
    chk("clean_noise_cleared", {31'd0, noise_err}, 32'd0);
    idle_ticks(2);

    // reset after 4th bit_vld, then 0x5A
    f0 = frame_cnt;
    abort_at = vld_cnt + 4;
    send_frame(8'h96, 1'b1, -1);
    abort_at = -1;
    chk("abort_no_frame", frame_cnt - f0, 32'd0);
    idle_ticks(4);
    v0 = vld_cnt; f0 = frame_cnt; e0 = err_cnt;
    send_frame(8'h5A, 1'b1, -1);
    chk("post_rst_vld", vld_cnt - v0, 32'd9);
    chk("post_rst_frames", frame_cnt - f0, 32'd1);
    chk("post_rst_err", err_cnt - e0, 32'd0);
    idle_ticks(2);

    // back-to-back 0x01, 0x80
    v0 = vld_cnt; f0 = frame_cnt; e0 = err_cnt;
    send_frame(8'h01, 1'b1, -1);
    send_frame(8'h80, 1'b1, -1);
    chk("b2b_vld", vld_cnt - v0, 32'd18);
    chk("b2b_frames", frame_cnt - f0, 32'd2);
    chk("b2b_err", err_cnt - e0, 32'd0);
    idle_ticks(4);
    chk("final_exp_empty", exp_q.size(), 32'd0);
    chk("final_idle", {29'd0, dbg_state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
